// File: rtl/cpu_rf_pkg.sv
// Shared constants for the CPU register file: default geometry and the
// per-register scoreboard state encoding.
package cpu_rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 3;
    localparam int RF_NUM_RD = 2;
    localparam int DEPTH     = 2 ** RF_ADDR_W;

    localparam logic RF_IDLE    = 1'b0;
    localparam logic RF_PENDING = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero register beats bypass, bypass beats the
// stored value. Busy is suppressed whenever the returned data is already valid.
module rf_read_port
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
)(
    input  logic [DATA_W-1:0]      regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   busy,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_busy
);

    logic is_zero;
    logic hit;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (rd_addr == '0);
        hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && !is_zero;
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
        if (hit) begin
            rd_data = wr_data;
            rd_busy = RF_IDLE;
        end
        if (is_zero) begin
            rd_data = '0;
            rd_busy = RF_IDLE;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with NUM_RD combinational read ports, one
// synchronous write port, optional bypass and a per-register busy scoreboard.
module regfile_scoreboard
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     alloc_ok,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic              wr_live;
    logic              alloc_zero;

    assign wr_live    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign alloc_zero = (ZERO_REG != 0) && (alloc_addr == '0);

    // alloc_en/alloc_ok is a request/grant pair: the request is taken on the
    // edge where both are high; a denied requester holds and retries. A write
    // retiring the same register this cycle frees it for the new producer.
    assign alloc_ok = alloc_en &&
                      (alloc_zero || (busy[alloc_addr] == RF_IDLE) ||
                       (wr_en && (wr_addr == alloc_addr)));

    // Alloc is applied after the write so a same-edge grant leaves it PENDING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
            busy <= '0;
        end else begin
            if (wr_live) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= RF_IDLE;
            end
            if (alloc_ok && !alloc_zero) busy[alloc_addr] <= RF_PENDING;
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .regs    (regs),
            .busy    (busy),
            .rd_addr (rd_addr[i*ADDR_W +: ADDR_W]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Two register files (bypass/no-zero-reg and zero-reg/no-bypass) driven from
// shared inputs and checked against an array-based model via an expected queue.
module tb_regfile_scoreboard;

    localparam int W    = 150;
    localparam int DW   = 75;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic        alloc_en;
    logic [2:0]  alloc_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        alloc_ok_a, alloc_ok_b;
    logic [7:0]  busy_vec_a, busy_vec_b;

    logic [W-1:0] exp_q[$];
    int tests  = 0;
    int errors = 0;

    // Reference state: one register array and busy set per configuration.
    logic [31:0] m_mem [2][8];
    logic [7:0]  m_busy [2];
    int cfg_zr  [2] = '{0, 1};
    int cfg_byp [2] = '{1, 0};

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .alloc_ok(alloc_ok_a), .busy_vec(busy_vec_a)
    );

    regfile_scoreboard #(.ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .alloc_ok(alloc_ok_b), .busy_vec(busy_vec_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_zero_reg(int d, logic [2:0] a);
        return (cfg_zr[d] != 0) && (a == 3'd0);
    endfunction

    function automatic logic model_grant(int d);
        if (!alloc_en) return 1'b0;
        if (is_zero_reg(d, alloc_addr)) return 1'b1;
        return !m_busy[d][alloc_addr] || (wr_en && wr_addr == alloc_addr);
    endfunction

    function automatic logic [W-1:0] build_exp();
        logic [W-1:0]  v;
        logic [DW-1:0] s;
        logic [2:0]    a;
        logic [31:0]   dat;
        logic          bsy;
        v = '0;
        for (int d = 0; d < 2; d++) begin
            s = '0;
            for (int i = 0; i < 2; i++) begin
                a = rd_addr[i*3 +: 3];
                if (is_zero_reg(d, a)) begin
                    dat = 32'h0; bsy = 1'b0;
                end else if (cfg_byp[d] != 0 && wr_en && wr_addr == a) begin
                    dat = wr_data; bsy = 1'b0;
                end else begin
                    dat = m_mem[d][a]; bsy = m_busy[d][a];
                end
                s[i*32 +: 32] = dat;
                s[64 + i]     = bsy;
            end
            s[66]    = model_grant(d);
            s[74:67] = m_busy[d];
            v[d*DW +: DW] = s;
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) m_mem[d][k] = 32'h0;
            m_busy[d] = 8'h00;
        end
    endtask

    // Applies the edge using the inputs that were held across it.
    task automatic model_edge();
        logic g;
        for (int d = 0; d < 2; d++) begin
            g = model_grant(d);
            if (wr_en && !is_zero_reg(d, wr_addr)) begin
                m_mem[d][wr_addr]  = wr_data;
                m_busy[d][wr_addr] = 1'b0;
            end
            if (g && !is_zero_reg(d, alloc_addr)) m_busy[d][alloc_addr] = 1'b1;
        end
    endtask

    // driver: one call per cycle, inputs change 1 time unit after posedge
    task automatic drive(input logic r, input logic we, input logic [2:0] wa,
                         input logic [31:0] wd, input logic ae, input logic [2:0] aa,
                         input logic [2:0] r0, input logic [2:0] r1);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        rst_n      = r;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        alloc_en   = ae;
        alloc_addr = aa;
        rd_addr    = {r1, r0};
        if (!r) model_clear();
        exp_q.push_back(build_exp());
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard: outputs are combinational, compared mid-cycle
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_rd_data",  {rd_data_a},               e[63:0]);
                check("a_rd_busy",  {62'h0, rd_busy_a},        {62'h0, e[65:64]});
                check("a_alloc_ok", {63'h0, alloc_ok_a},       {63'h0, e[66]});
                check("a_busy_vec", {56'h0, busy_vec_a},       {56'h0, e[74:67]});
                check("b_rd_data",  {rd_data_b},               e[DW+63:DW]);
                check("b_rd_busy",  {62'h0, rd_busy_b},        {62'h0, e[DW+65:DW+64]});
                check("b_alloc_ok", {63'h0, alloc_ok_b},       {63'h0, e[DW+66]});
                check("b_busy_vec", {56'h0, busy_vec_b},       {56'h0, e[DW+74:DW+67]});
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
        model_clear();

        drive(0, 0, 0, 32'h0, 0, 0, 0, 3);
        drive(0, 0, 0, 32'h0, 0, 0, 5, 7);
        // write latency, bypass, zero register
        drive(1, 1, 0, 32'hACEDCAFE, 0, 0, 0, 3);
        drive(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3);
        drive(1, 0, 0, 32'h0,        0, 0, 0, 3);
        drive(1, 1, 7, 32'hDEADBEEF, 0, 0, 7, 3);
        drive(1, 0, 0, 32'h0,        0, 0, 7, 0);
        // scoreboard lifecycle
        drive(1, 0, 0, 32'h0,        1, 5, 5, 0);
        drive(1, 0, 0, 32'h0,        1, 5, 5, 1);
        drive(1, 1, 5, 32'h12345678, 0, 0, 5, 5);
        drive(1, 0, 0, 32'h0,        0, 0, 5, 5);
        // WAW chaining
        drive(1, 0, 0, 32'h0,        1, 2, 2, 2);
        drive(1, 1, 2, 32'hFFFFFFFF, 1, 2, 2, 0);
        drive(1, 0, 0, 32'h0,        0, 0, 2, 2);
        // zero register write and alloc
        drive(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,        1, 0, 0, 0);
        drive(1, 0, 0, 32'h0,        0, 0, 0, 1);
        // write strobe low leaves r7 alone, both ports on r7
        drive(1, 0, 7, 32'hFFFFFFFF, 0, 0, 7, 7);
        drive(1, 0, 0, 32'h0,        0, 0, 7, 7);
        // asynchronous reset mid-run, checked before any further edge
        drive(1, 1, 0, 32'hACEDCAFE, 1, 4, 0, 4);
        drive(0, 0, 0, 32'h0,        0, 0, 0, 4);
        drive(1, 0, 0, 32'h0,        0, 0, 0, 4);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0)
                drive(0, 0, 0, 32'h0, 0, 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else
                drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
